// File: rtl/serv_dbg_inject.sv
// ============================================================================
// serv_dbg_inject : runs debug abstract GPR commands by feeding the core a
//                   lw/sw through DATA_ADDR followed by an ebreak. Rev 1.0
// ============================================================================
`default_nettype none

module serv_dbg_inject #(
  parameter logic [11:0] DATA_ADDR   = 12'h7FC,
  parameter logic [31:0] EBREAK_WORD = 32'h00100073
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [4:0]  i_cmd_regno,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [11:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INJ0 = 2'd1,
    S_INJ1 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [4:0]  r_regno;
  logic [31:0] r_data;
  logic        r_ibus_ack;
  logic [31:0] r_ibus_rdt;
  logic        r_dbus_ack;
  logic [31:0] r_dbus_rdt;

  logic        w_inj;
  logic        w_fetch;
  logic        w_dbus_hit;
  logic [31:0] w_lw;
  logic [31:0] w_sw;
  logic [31:0] w_insn;

  // A write command loads the GPR from the data register; a read stores it there.
  assign w_lw   = {DATA_ADDR, 5'd0, 3'b010, r_regno, 7'b0000011};
  assign w_sw   = {DATA_ADDR[11:5], r_regno, 5'd0, 3'b010, DATA_ADDR[4:0], 7'b0100011};
  assign w_insn = (r_state == S_INJ0) ? (r_write ? w_lw : w_sw) : EBREAK_WORD;

  // Gating on the current ack keeps each handshake a single-cycle pulse while
  // the core still holds cyc during the ack cycle.
  assign w_inj      = (r_state == S_INJ0) || (r_state == S_INJ1);
  assign w_fetch    = i_ibus_cyc && !r_ibus_ack && w_inj;
  assign w_dbus_hit = i_dbus_cyc && (i_dbus_adr == DATA_ADDR) && !r_dbus_ack;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_regno    <= 5'd0;
      r_data     <= 32'd0;
      r_ibus_ack <= 1'b0;
      r_ibus_rdt <= 32'd0;
      r_dbus_ack <= 1'b0;
      r_dbus_rdt <= 32'd0;
    end else begin
      r_ibus_ack <= w_fetch;
      r_ibus_rdt <= w_fetch ? w_insn : 32'd0;
      r_dbus_ack <= w_dbus_hit;
      r_dbus_rdt <= (w_dbus_hit && !i_dbus_we) ? r_data : 32'd0;

      if (r_dbus_ack && i_dbus_we) begin
        r_data <= i_dbus_dat;
      end

      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_write <= i_cmd_write;
            r_regno <= i_cmd_regno;
            if (i_cmd_write) begin
              r_data <= i_cmd_data;
            end
            r_state <= S_INJ0;
          end
        end
        S_INJ0: begin
          if (r_ibus_ack) begin
            r_state <= S_INJ1;
          end
        end
        S_INJ1: begin
          if (r_ibus_ack) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_data  = r_data;
  assign o_ibus_ack  = r_ibus_ack;
  assign o_ibus_rdt  = r_ibus_rdt;
  assign o_dbus_ack  = r_dbus_ack;
  assign o_dbus_rdt  = r_dbus_rdt;

endmodule

`default_nettype wire

// File: tb/tb_serv_dbg_inject.sv
// ============================================================================
// tb_serv_dbg_inject : self-checking bench for serv_dbg_inject. Rev 1.0
// ============================================================================
`default_nettype none

module tb_serv_dbg_inject;

  localparam logic [11:0] C_DATA_ADDR = 12'h7FC;
  localparam logic [31:0] C_EBREAK    = 32'h00100073;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [4:0]  i_cmd_regno;
  logic [31:0] i_cmd_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [11:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  serv_dbg_inject #(
    .DATA_ADDR   (C_DATA_ADDR),
    .EBREAK_WORD (C_EBREAK)
  ) u_dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_regno (i_cmd_regno),
    .i_cmd_data  (i_cmd_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .i_ibus_cyc  (i_ibus_cyc),
    .o_ibus_rdt  (o_ibus_rdt),
    .o_ibus_ack  (o_ibus_ack),
    .i_dbus_adr  (i_dbus_adr),
    .i_dbus_dat  (i_dbus_dat),
    .i_dbus_we   (i_dbus_we),
    .i_dbus_cyc  (i_dbus_cyc),
    .o_dbus_rdt  (o_dbus_rdt),
    .o_dbus_ack  (o_dbus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [4:0]  regno;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic [31:0] exp_insn;
    logic [31:0] exp_rsp;
    int          stall;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (i_rst_n && i_cmd_valid && o_cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no handshake expected one within 20 cycles", name);
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxxxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic push_seq(input logic write, input logic [31:0] insn,
                          input logic [31:0] wdata, input logic [31:0] rsp);
    exp_q.push_back(insn);
    if (write) exp_q.push_back(wdata);
    exp_q.push_back(C_EBREAK);
    exp_q.push_back(rsp);
  endtask

  task automatic issue_cmd(input string name, input logic write, input logic [4:0] regno,
                           input logic [31:0] data, input bit hold);
    int k = 0;
    while (!o_cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!o_cmd_ready) fail_timeout({name, "_ready"});
    i_cmd_valid = 1'b1;
    i_cmd_write = write;
    i_cmd_regno = regno;
    i_cmd_data  = data;
    @(negedge clk);
    if (!hold) i_cmd_valid = 1'b0;
    check({name, "_busy"}, {31'd0, o_cmd_ready}, 32'd0);
  endtask

  task automatic do_fetch(input string name);
    bit          got = 0;
    int          k = 0;
    logic [31:0] e;
    e = pop_exp();
    i_ibus_cyc = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (o_ibus_ack) got = 1;
    end
    if (got) begin
      check(name, o_ibus_rdt, e);
      @(negedge clk);
      check({name, "_pulse"}, {31'd0, o_ibus_ack}, 32'd0);
    end else begin
      fail_timeout(name);
    end
    i_ibus_cyc = 1'b0;
  endtask

  task automatic dbus_xfer(input string name, input logic we, input logic [31:0] dat);
    bit got = 0;
    int k = 0;
    i_dbus_adr = C_DATA_ADDR;
    i_dbus_we  = we;
    i_dbus_dat = dat;
    i_dbus_cyc = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (o_dbus_ack) got = 1;
    end
    if (got) begin
      if (!we) check(name, o_dbus_rdt, pop_exp());
      @(negedge clk);
      check({name, "_pulse"}, {31'd0, o_dbus_ack}, 32'd0);
    end else begin
      if (!we) void'(pop_exp());
      fail_timeout(name);
    end
    i_dbus_cyc = 1'b0;
    i_dbus_we  = 1'b0;
  endtask

  task automatic do_resp(input string name, input int stall);
    bit          got = 0;
    int          k = 0;
    logic [31:0] e;
    e = pop_exp();
    while (!got && k < 20) begin
      if (o_rsp_valid) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      fail_timeout(name);
      return;
    end
    check(name, o_rsp_data, e);
    check({name, "_busy"}, {31'd0, o_cmd_ready}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({name, "_stall_valid"}, {31'd0, o_rsp_valid}, 32'd1);
      check({name, "_stall_data"}, o_rsp_data, e);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check({name, "_done"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  task automatic serve_core(input string pfx, input logic write,
                            input logic [31:0] sdata, input int stall);
    do_fetch({pfx, "_insn0"});
    if (write) dbus_xfer({pfx, "_load"}, 1'b0, 32'd0);
    else       dbus_xfer({pfx, "_store"}, 1'b1, sdata);
    do_fetch({pfx, "_ebreak"});
    do_resp({pfx, "_rsp"}, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int cnt;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        32'h7FC02283, 32'hDEADBEEF, 0};
    vecs[1] = '{1'b0, 5'd10, 32'h0,        32'h12345678, 32'h7EA02E23, 32'h12345678, 5};
    vecs[2] = '{1'b1, 5'd0,  32'h55AA55AA, 32'h0,        32'h7FC02003, 32'h55AA55AA, 0};
    vecs[3] = '{1'b0, 5'd31, 32'h0,        32'hA5A50F0F, 32'h7FF02E23, 32'hA5A50F0F, 1};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 32'h0,        32'h7FC02083, 32'h00000001, 0};
    vecs[5] = '{1'b0, 5'd1,  32'h0,        32'hFFFFFFFF, 32'h7E102E23, 32'hFFFFFFFF, 2};

    i_rst_n = 1'b0;  i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_regno = 5'd0;
    i_cmd_data = 32'd0; i_rsp_ready = 1'b0; i_ibus_cyc = 1'b1; i_dbus_adr = C_DATA_ADDR;
    i_dbus_dat = 32'd0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;

    // Reset state, with both buses requesting throughout.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_ibus_ack",  {31'd0, o_ibus_ack},  32'd0);
    check("rst_dbus_ack",  {31'd0, o_dbus_ack},  32'd0);
    check("rst_ibus_rdt",  o_ibus_rdt, 32'd0);
    check("rst_dbus_rdt",  o_dbus_rdt, 32'd0);
    check("rst_rsp_data",  o_rsp_data, 32'd0);
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    i_rst_n    = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      string pfx;
      pfx = $sformatf("v%0d", i);
      push_seq(vecs[i].write, vecs[i].exp_insn, vecs[i].wdata, vecs[i].exp_rsp);
      issue_cmd(pfx, vecs[i].write, vecs[i].regno, vecs[i].wdata, 1'b0);
      serve_core(pfx, vecs[i].write, vecs[i].sdata, vecs[i].stall);
    end

    // Data port works in IDLE too: a load returns the last data register value.
    exp_q.push_back(vecs[5].exp_rsp);
    dbus_xfer("idle_load", 1'b0, 32'd0);

    // Fetch in IDLE and an access at a non-matching address are never acked.
    i_ibus_cyc = 1'b1;
    i_dbus_adr = 12'h7F8;
    i_dbus_cyc = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_ibus_ack || o_dbus_ack || (o_ibus_rdt != 32'd0)) cnt++;
    end
    check("idle_no_ack", cnt, 32'd0);
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    i_dbus_adr = C_DATA_ADDR;
    @(negedge clk);

    // cmd_valid held across a whole command, then still high while the response
    // is consumed: exactly one accept, and the re-accept comes a cycle later.
    acc0 = acc_cnt;
    push_seq(1'b1, 32'h7FC02103, 32'h0BADF00D, 32'h0BADF00D);
    push_seq(1'b1, 32'h7FC02103, 32'h0BADF00D, 32'h0BADF00D);
    issue_cmd("hold", 1'b1, 5'd2, 32'h0BADF00D, 1'b1);
    serve_core("hold", 1'b1, 32'd0, 0);
    check("hold_one_accept", acc_cnt - acc0, 32'd1);
    check("hold_idle_ready", {31'd0, o_cmd_ready}, 32'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("hold_reaccept", acc_cnt - acc0, 32'd2);
    serve_core("hold2", 1'b1, 32'd0, 0);
    check("hold_total", acc_cnt - acc0, 32'd2);

    // Simultaneous fetch and data requests.
    issue_cmd("sim", 1'b1, 5'd7, 32'hCAFEF00D, 1'b0);
    exp_q.push_back(C_EBREAK);
    exp_q.push_back(32'hCAFEF00D);
    i_ibus_cyc = 1'b1;
    i_dbus_cyc = 1'b1;
    i_dbus_we  = 1'b0;
    @(negedge clk);
    check("sim_ibus_ack", {31'd0, o_ibus_ack}, 32'd1);
    check("sim_dbus_ack", {31'd0, o_dbus_ack}, 32'd1);
    check("sim_ibus_rdt", o_ibus_rdt, 32'h7FC02383);
    check("sim_dbus_rdt", o_dbus_rdt, 32'hCAFEF00D);
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    @(negedge clk);
    do_fetch("sim_ebreak");
    do_resp("sim_rsp", 0);

    // Reset after the first fetch aborts the command without a response.
    exp_q.push_back(32'h7FC02183);
    issue_cmd("abort", 1'b1, 5'd3, 32'h33333333, 1'b0);
    do_fetch("abort_insn0");
    #2 i_rst_n = 1'b0;
    #1;
    check("abort_rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("abort_rst_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("abort_rst_data",  o_rsp_data, 32'd0);
    @(negedge clk);
    i_rst_n    = 1'b1;
    i_ibus_cyc = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_rsp_valid || o_ibus_ack) cnt++;
    end
    check("abort_no_rsp", cnt, 32'd0);
    i_ibus_cyc = 1'b0;
    push_seq(1'b1, 32'h7FC02083, 32'h13579BDF, 32'h13579BDF);
    issue_cmd("after", 1'b1, 5'd1, 32'h13579BDF, 1'b0);
    serve_core("after", 1'b1, 32'd0, 0);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
